// File: rtl/bg_scroll_renderer.sv
// Scrolling, down-scaled background renderer: beam position -> index ROM address -> palette RGB.
// Macro BG_WRAP_EN: when defined, source coordinates wrap; when undefined, out-of-range pixels render black.
module bg_scroll_renderer #(
   parameter int SRC_W       = 320,
   parameter int SRC_H       = 240,
   parameter int SCALE_SHIFT = 1,
   parameter int IDX_W       = 5,
   parameter int ROM_LAT     = 1,
   parameter int ADDR_W      = 17
) (
   input  logic                       vga_clk,
   input  logic                       reset_n,
   input  logic [9:0]                 DrawX,
   input  logic [9:0]                 DrawY,
   input  logic                       blank,
   input  logic                       scroll_valid,
   output logic                       scroll_ready,
   input  logic [$clog2(SRC_W)-1:0]   scroll_x,
   input  logic [$clog2(SRC_H)-1:0]   scroll_y,
   input  logic                       scroll_auto,
   input  logic [3:0]                 scroll_vel,
   output logic                       scroll_err,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [IDX_W-1:0]           rom_q,
   output logic [IDX_W-1:0]           pal_index,
   input  logic [3:0]                 pal_red,
   input  logic [3:0]                 pal_green,
   input  logic [3:0]                 pal_blue,
   output logic [3:0]                 red,
   output logic [3:0]                 green,
   output logic [3:0]                 blue
);

   localparam int XW = $clog2(SRC_W);
   localparam int YW = $clog2(SRC_H);
   localparam int MW = (XW > YW) ? XW : YW;
   localparam int SW = ((MW > 10) ? MW : 10) + 1;

   localparam logic signed [XW+1:0] W_S  = (XW+2)'(SRC_W);
   localparam logic [XW:0]          W_X1 = (XW+1)'(SRC_W);
   localparam logic [YW:0]          H_Y1 = (YW+1)'(SRC_H);
   localparam logic [SW-1:0]        W_SW = SW'(SRC_W);
   localparam logic [SW-1:0]        H_SW = SW'(SRC_H);
   localparam logic [ADDR_W-1:0]    W_A  = ADDR_W'(SRC_W);

   logic [XW-1:0] off_x, pend_x, nxt_x;
   logic [YW-1:0] off_y, pend_y, nxt_y;
   logic          auto_en, pend_auto, nxt_auto;
   logic [3:0]    vel, pend_vel, nxt_vel;
   logic          pend_valid;

   logic          fs;
   logic          accept;
   logic          bad;
   logic signed [XW+1:0] adv;
   logic [XW-1:0] adv_w;

   logic [SW-1:0] sum_x, sum_y;
   logic          over_x, over_y;
   logic [XW-1:0] sx;
   logic [YW-1:0] sy;
   logic          border;
   logic [ADDR_W-1:0] addr_c;

   logic [ROM_LAT:0] blank_d;
   logic [ROM_LAT:0] border_d;

   assign fs           = (DrawX == 10'd0) && (DrawY == 10'd0);
   assign scroll_ready = !pend_valid;
   assign accept       = scroll_valid && !pend_valid;
   assign bad          = ({1'b0, scroll_x} >= W_X1) || ({1'b0, scroll_y} >= H_Y1);
   assign pal_index    = rom_q;

   // Signed auto-scroll step; |vel| <= 8 so one correction in either direction suffices.
   always_comb begin
      adv = $signed({2'b00, off_x}) + $signed({{(XW-2){scroll_vel_sign(vel)}}, vel});
      if (adv[XW+1])
         adv_w = XW'(adv + W_S);
      else if (adv >= W_S)
         adv_w = XW'(adv - W_S);
      else
         adv_w = XW'(adv);
   end

   function automatic logic scroll_vel_sign(input logic [3:0] v);
      return v[3];
   endfunction

   // Offsets as seen by the current pixel: the FS pixel already uses the committed values.
   always_comb begin
      nxt_x    = off_x;
      nxt_y    = off_y;
      nxt_auto = auto_en;
      nxt_vel  = vel;
      if (fs && pend_valid) begin
         nxt_x    = pend_x;
         nxt_y    = pend_y;
         nxt_auto = pend_auto;
         nxt_vel  = pend_vel;
      end else if (fs && auto_en) begin
         nxt_x = adv_w;
      end
   end

   always_comb begin
      sum_x  = SW'(DrawX >> SCALE_SHIFT) + SW'(nxt_x);
      sum_y  = SW'(DrawY >> SCALE_SHIFT) + SW'(nxt_y);
      over_x = (sum_x >= W_SW);
      over_y = (sum_y >= H_SW);
`ifdef BG_WRAP_EN
      sx     = XW'(over_x ? sum_x - W_SW : sum_x);
      sy     = YW'(over_y ? sum_y - H_SW : sum_y);
      border = 1'b0;
`else
      sx     = XW'(sum_x);
      sy     = YW'(sum_y);
      border = over_x || over_y;
`endif
      if (border)
         addr_c = '0;
      else
         addr_c = ADDR_W'(sy) * W_A + ADDR_W'(sx);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         off_x      <= '0;
         off_y      <= '0;
         auto_en    <= 1'b0;
         vel        <= '0;
         pend_valid <= 1'b0;
         pend_x     <= '0;
         pend_y     <= '0;
         pend_auto  <= 1'b0;
         pend_vel   <= '0;
         scroll_err <= 1'b0;
      end else begin
         off_x      <= nxt_x;
         off_y      <= nxt_y;
         auto_en    <= nxt_auto;
         vel        <= nxt_vel;
         scroll_err <= accept && bad;
         if (fs && pend_valid) begin
            pend_valid <= 1'b0;
         end else if (accept && !bad) begin
            pend_valid <= 1'b1;
            pend_x     <= scroll_x;
            pend_y     <= scroll_y;
            pend_auto  <= scroll_auto;
            pend_vel   <= scroll_vel;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr <= '0;
         blank_d  <= '0;
         border_d <= '0;
         red      <= '0;
         green    <= '0;
         blue     <= '0;
      end else begin
         rom_addr <= addr_c;
         blank_d  <= {blank_d[ROM_LAT-1:0], blank};
         border_d <= {border_d[ROM_LAT-1:0], border};
         if (blank_d[ROM_LAT] && !border_d[ROM_LAT]) begin
            red   <= pal_red;
            green <= pal_green;
            blue  <= pal_blue;
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Randomized bench for bg_scroll_renderer against a frame-level scroll/address model.
module tb_bg_scroll_renderer;

   localparam int SRC_W  = 320;
   localparam int SRC_H  = 240;
   localparam int ADDR_W = 17;

   logic        vga_clk;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY;
   logic        blank;
   logic        scroll_valid;
   logic        scroll_ready;
   logic [8:0]  scroll_x;
   logic [7:0]  scroll_y;
   logic        scroll_auto;
   logic [3:0]  scroll_vel;
   logic        scroll_err;
   logic [ADDR_W-1:0] rom_addr;
   logic [4:0]  rom_q;
   logic [4:0]  pal_index;
   logic [3:0]  pal_red, pal_green, pal_blue;
   logic [3:0]  red, green, blue;

   bg_scroll_renderer dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .scroll_valid(scroll_valid), .scroll_ready(scroll_ready), .scroll_x(scroll_x),
      .scroll_y(scroll_y), .scroll_auto(scroll_auto), .scroll_vel(scroll_vel),
      .scroll_err(scroll_err), .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
      .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
      .red(red), .green(green), .blue(blue)
   );

   function automatic logic [4:0] rom_fn(input logic [16:0] a);
      return a[4:0] ^ a[9:5] ^ a[14:10] ^ {3'b000, a[16:15]};
   endfunction

   function automatic logic [11:0] pal_of(input logic [4:0] i);
      logic [3:0] r, g, b;
      r = i[3:0];
      g = {i[4], i[2:0]} ^ 4'h9;
      b = ~i[3:0];
      return {r, g, b};
   endfunction

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);
   assign {pal_red, pal_green, pal_blue} = pal_of(pal_index);

   int n_checks = 0;
   int n_fail   = 0;

   // scroll model state
   int m_off_x, m_off_y, m_auto, m_vel;
   int m_pend, p_x, p_y, p_auto, p_vel;
   int e_err;
   int rgb_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_off_x = 0; m_off_y = 0; m_auto = 0; m_vel = 0;
      m_pend = 0; p_x = 0; p_y = 0; p_auto = 0; p_vel = 0;
      e_err = 0;
      rgb_q = {};
      rgb_q.push_back(0);
      rgb_q.push_back(0);
   endtask

   task automatic step(input int x, input int y, input int b, input int sv,
                       input int sx, input int sy, input int sa, input int svel);
      int ax, ay, brd, e_addr, rgb, was_pend;
      DrawX        = 10'(x);
      DrawY        = 10'(y);
      blank        = b[0];
      scroll_valid = sv[0];
      scroll_x     = 9'(sx);
      scroll_y     = 8'(sy);
      scroll_auto  = sa[0];
      scroll_vel   = 4'(svel);

      was_pend = m_pend;
      if (x == 0 && y == 0) begin
         if (m_pend != 0) begin
            m_off_x = p_x; m_off_y = p_y; m_auto = p_auto; m_vel = p_vel;
            m_pend = 0;
         end else if (m_auto != 0) begin
            m_off_x = ((m_off_x + m_vel) % SRC_W + SRC_W) % SRC_W;
         end
      end

      ax = (x >> 1) + m_off_x;
      ay = (y >> 1) + m_off_y;
`ifdef BG_WRAP_EN
      ax  = ax % SRC_W;
      ay  = ay % SRC_H;
      brd = 0;
`else
      brd = (ax >= SRC_W || ay >= SRC_H) ? 1 : 0;
`endif
      e_addr = brd ? 0 : ay * SRC_W + ax;
      rgb    = (b != 0 && brd == 0) ? int'(pal_of(rom_fn(17'(e_addr)))) : 0;
      rgb_q.push_back(rgb);

      e_err = 0;
      if (sv != 0 && was_pend == 0) begin
         if (sx >= SRC_W || sy >= SRC_H) begin
            e_err = 1;
         end else begin
            m_pend = 1; p_x = sx; p_y = sy; p_auto = sa; p_vel = svel;
         end
      end

      @(posedge vga_clk);
      #1;
      chk("rom_addr", int'(rom_addr), e_addr);
      chk("rgb", int'({red, green, blue}), rgb_q.pop_front());
      chk("scroll_err", int'(scroll_err), e_err);
      chk("scroll_ready", int'(scroll_ready), m_pend == 0 ? 1 : 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(100 + 2 * i, 60, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      #1;
      chk("rst_addr", int'(rom_addr), 0);
      chk("rst_rgb", int'({red, green, blue}), 0);
      chk("rst_err", int'(scroll_err), 0);
      chk("rst_ready", int'(scroll_ready), 1);
      model_reset();
      scroll_valid = 1'b0;
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      DrawX = 10'd100; DrawY = 10'd60; blank = 1'b0;
      scroll_valid = 1'b0; scroll_x = '0; scroll_y = '0; scroll_auto = 1'b0; scroll_vel = '0;
      model_reset();
      repeat (3) @(posedge vga_clk);
      #1;
      chk("init_addr", int'(rom_addr), 0);
      chk("init_rgb", int'({red, green, blue}), 0);
      chk("init_ready", int'(scroll_ready), 1);
      chk("init_err", int'(scroll_err), 0);
      @(negedge vga_clk);
      reset_n = 1'b1;

      // idle addressing and output latency
      step(2, 2, 1, 0, 0, 0, 0, 0);
      chk("addr_321", int'(rom_addr), 321);
      step(4, 2, 0, 0, 0, 0, 0, 0);
      idle(3);

      // mid-frame request commits only at FS
      step(50, 50, 1, 1, 10, 0, 0, 0);
      chk("ready_low", int'(scroll_ready), 0);
      idle(4);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      chk("fs_addr_10", int'(rom_addr), 10);
      chk("ready_rise", int'(scroll_ready), 1);
      idle(2);

      // out-of-range request rejected
      step(80, 20, 1, 1, 320, 0, 0, 0);
      chk("err_pulse", int'(scroll_err), 1);
      chk("err_ready", int'(scroll_ready), 1);
      step(82, 20, 1, 0, 0, 0, 0, 0);
      chk("err_once", int'(scroll_err), 0);
      idle(2);

      // auto-scroll with negative velocity wraps off_x 0 -> 319
      step(40, 40, 1, 1, 0, 0, 1, -1);
      idle(2);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      idle(3);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      chk("auto_319", int'(rom_addr), 319);
      step(2, 0, 1, 0, 0, 0, 0, 0);
      idle(3);
      step(40, 40, 1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      idle(3);

      // request in FS cycle waits for the next FS; second request held off
      step(0, 0, 1, 1, 5, 3, 0, 0);
      chk("fs_req_ready", int'(scroll_ready), 0);
      step(30, 30, 1, 1, 7, 9, 0, 0);
      chk("held_off", int'(scroll_ready), 0);
      idle(3);
      step(0, 0, 1, 0, 0, 0, 0, 0);
      chk("fs_addr_965", int'(rom_addr), 965);
      idle(3);

      // reset with pending request
      step(60, 60, 1, 1, 20, 20, 0, 0);
      reset_pulse();
      step(0, 0, 1, 0, 0, 0, 0, 0);
      chk("discarded", int'(rom_addr), 0);
      idle(3);

      // randomized traffic with periodic frame starts
      for (int i = 0; i < 3000; i++) begin
         int x, y;
         x = $urandom_range(639, 0);
         y = $urandom_range(479, 0);
         if (i % 40 == 0) begin
            x = 0; y = 0;
         end
         step(x, y, ($urandom_range(3, 0) != 0) ? 1 : 0,
              ($urandom_range(9, 0) == 0) ? 1 : 0,
              $urandom_range(335, 0), $urandom_range(250, 0),
              $urandom_range(1, 0), int'($urandom_range(15, 0)) - 8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bg_scroll_renderer.md
# bg_scroll_renderer

Parametrised background renderer for the VGA path. It maps the current DrawX/DrawY beam position to a down-scaled source image with a per-frame scroll offset, and drives the address of an external index ROM. The returned colour index goes through an external palette, and the block produces registered 4-bit RGB aligned with a delayed blank. It sits between the VGA controller and the colour mixer, in the same slot as the fixed 320x240 background renderer it replaces. It adds frame-synchronous scroll updates through a valid/ready handshake and an auto-scroll mode.

## Interface
- SRC_W, 320: source image width in pixels
- SRC_H, 240: source image height in pixels
- SCALE_SHIFT, 1: screen-to-source downscale; source coord = screen coord >> SCALE_SHIFT
- IDX_W, 5: palette index width
- ROM_LAT, 1: ROM read latency in cycles (1..3)
- ADDR_W, 17: ROM address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H
- vga_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  beam position
- blank  in  1  1 = active video
- scroll_valid  in  1  offset update request
- scroll_ready  out  1  update slot free
- scroll_x  in  $clog2(SRC_W)  requested x offset
- scroll_y  in  $clog2(SRC_H)  requested y offset
- scroll_auto  in  1  1 = auto-scroll mode (sampled with request)
- scroll_vel  in  4  signed per-frame x velocity (sampled with request)
- scroll_err  out  1  one-cycle pulse: request rejected
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after rom_addr
- pal_index  out  IDX_W  equals rom_q (to combinational palette)
- pal_red, pal_green, pal_blue  in  4 each  palette colour
- red, green, blue  out  4 each  registered pixel colour

## Operation
- Active registers: off_x, off_y, auto, vel. One pending slot: pend_valid, pend_x, pend_y, pend_auto, pend_vel.
- Handshake:
  - scroll_ready = !pend_valid.
  - A request is accepted when scroll_valid && scroll_ready.
  - If the accepted request has scroll_x >= SRC_W or scroll_y >= SRC_H, it is dropped. scroll_err pulses the next cycle and the slot stays empty.
- Frame start (FS) is any cycle with DrawX==0 && DrawY==0.
  - On FS with pend_valid: the active registers load from the slot and pend_valid clears.
  - On FS without pend_valid and with auto=1: off_x <= (off_x + vel) mod SRC_W. Signed wrap in both directions, e.g. 0 + (-1) -> SRC_W-1.
  - The address computed in the FS cycle uses the newly committed/advanced offsets through a bypass mux. The whole frame therefore uses one offset.
- A request accepted in an FS cycle is not committed in that cycle. It waits for the next FS.
- Address stage (registered):
  - sx = ((DrawX>>SCALE_SHIFT) + off_x) reduced mod SRC_W by one conditional subtract.
  - sy is computed the same way with DrawY and SRC_H.
  - rom_addr <= sy*SRC_W + sx.
- blank is delayed ROM_LAT+1 cycles through a shift register. Output stage: if delayed blank, RGB <= pal_*; else RGB <= 0.
- Reset values: all outputs 0 except scroll_ready=1. off_x=off_y=0, auto=0, vel=0, pend_valid=0. Reset mid-frame discards any pending request.

## Timing
- Latency from DrawX/DrawY/blank to red/green/blue: ROM_LAT+2 cycles (3 at default).
- Throughput: one pixel per cycle, no stalls.
- scroll_ready drops the cycle after acceptance and rises the cycle after the committing FS.
- scroll_err is asserted exactly one cycle, 1 cycle after the rejected request.

## Configuration
- BG_WRAP_EN defined: out-of-range source coordinates wrap modulo SRC_W/SRC_H as above.
- BG_WRAP_EN undefined:
  - No modulo is applied. If the raw sum is >= SRC_W/SRC_H, rom_addr is 0.
  - The block forces RGB to 0 for that pixel using a border flag delayed alongside blank.
  - Auto-scroll still wraps off_x.

## Test plan
- Reset then idle, offsets 0: DrawX=2, DrawY=2 -> rom_addr=321 one cycle later; RGB = palette of rom_q, 3 cycles later; blank=0 -> RGB=0.
- Request x=10, y=0 mid-frame: scroll_ready falls next cycle. Addresses stay unchanged until FS. At FS, pixel (0,0) -> rom_addr=10 and scroll_ready rises.
- scroll_x=320 with SRC_W=320 -> scroll_err pulses 1 cycle, scroll_ready stays 1, offsets unchanged.
- Auto, vel=-1, off_x=0: after 1 FS off_x=319; with wrap, DrawX=0 -> sx=319. Without BG_WRAP_EN, DrawX=2 (sx raw 320) -> RGB 0.
- Request in the FS cycle: not applied until the following FS; a second scroll_valid while pending is held off (ready=0).
- Assert reset_n low with pend_valid=1 mid-frame -> all outputs 0 immediately, scroll_ready=1, pending discarded.
